if_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the instruction memory wrapper. Owns the program counter, computes the next fetch address each cycle, and drives it to instruction memory, which returns data one cycle later (synchronous SRAM). Pairs each returned word with its PC and presents a valid instruction to decode. Handles stall, branch redirect (MIPS delay-slot semantics), exception flush, and misaligned-fetch detection.

---
 rtl/if_fetch_unit.sv | 82 ++++++++
 tb/tb_if_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the program counter, drives the next fetch
// address to a synchronous instruction memory, and pairs each returned word
// with its PC for decode. Handles stall, delayed-branch redirect, exception
// flush and misaligned-fetch reporting.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic [31:0] de_pc,
    output logic [31:0] de_inst,
    output logic        de_valid,
    output logic        de_adel
);

    // r_pc is the address whose data is on im_data this cycle
    logic [31:0] r_pc;
    logic        r_valid;
    logic        r_pend;
    logic [31:0] r_pend_tgt;

    logic [31:0] w_next_pc;

    // Next fetch address: flush > stall (hold) > new branch > pending branch > sequential
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (flush) begin
            w_next_pc = flush_target;
        end else if (stall) begin
            w_next_pc = r_pc;
        end else if (br_taken) begin
            w_next_pc = br_target;
        end else if (r_pend) begin
            w_next_pc = r_pend_tgt;
        end
    end

    // During reset the memory is primed with the first instruction address
    assign im_addr = rst ? RESET_PC : w_next_pc;

    // Advance PC, track word validity and hold a branch that arrived while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC - 32'd4;
            r_valid    <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_tgt <= 32'd0;
        end else begin
            r_pc <= w_next_pc;
            if (flush || !stall) begin
                r_valid <= 1'b1;
            end
            if (flush) begin
                r_pend <= 1'b0;
            end else if (stall) begin
                if (br_taken) begin
                    // A later branch during the same stall replaces the earlier one
                    r_pend     <= 1'b1;
                    r_pend_tgt <= br_target;
                end
            end else begin
                r_pend <= 1'b0;
            end
        end
    end

    // Flush kills the word in flight in the same cycle; a taken branch does not
    // (that word is the delay slot)
    assign de_pc    = r_pc;
    assign de_valid = r_valid & ~flush & ~rst;
    assign de_adel  = de_valid & (r_pc[1:0] != 2'b00);
    assign de_inst  = (de_valid && !de_adel) ? im_data : NOP_INST;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random traffic, all
// checked each cycle against a behavioural model of the fetch stage.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] flush_target;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic [31:0] de_pc;
    logic [31:0] de_inst;
    logic        de_valid;
    logic        de_adel;

    int n_vec;
    int n_err;

    // behavioural model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_pend[$];

    if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .flush(flush), .flush_target(flush_target),
        .im_addr(im_addr), .im_data(im_data), .de_pc(de_pc), .de_inst(de_inst),
        .de_valid(de_valid), .de_adel(de_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory contents are a fixed function of address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // synchronous SRAM: one cycle read latency
    always @(posedge clk) im_data <= mem_word(im_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // where the model fetches next given the current inputs
    function automatic logic [31:0] m_next();
        if (rst)              return RST_PC;
        if (flush)            return flush_target;
        if (stall)            return m_pc;
        if (br_taken)         return br_target;
        if (m_pend.size() > 0) return m_pend[0];
        return m_pc + 32'd4;
    endfunction

    // drive inputs just after an edge, then compare all outputs mid-cycle
    task automatic apply(input logic r, input logic s, input logic b, input logic [31:0] bt,
                         input logic f, input logic [31:0] ft);
        logic        ev;
        logic        ea;
        rst = r; stall = s; br_taken = b; br_target = bt; flush = f; flush_target = ft;
        #4;
        ev = m_valid && !f && !r;
        ea = ev && (m_pc[1:0] != 2'b00);
        chk("im_addr",  im_addr, m_next());
        chk("de_pc",    de_pc, m_pc);
        chk("de_valid", 32'(de_valid), 32'(ev));
        chk("de_adel",  32'(de_adel), 32'(ea));
        chk("de_inst",  de_inst, (ev && !ea) ? mem_word(m_pc) : NOP);
    endtask

    // commit model state for this cycle and move past the edge
    task automatic tick();
        logic [31:0] nxt;
        nxt = m_next();
        if (rst) begin
            m_pc    = RST_PC - 32'd4;
            m_valid = 1'b0;
            m_pend.delete();
        end else begin
            if (flush) begin
                m_pend.delete();
            end else if (stall) begin
                if (br_taken) begin
                    m_pend.delete();
                    m_pend.push_back(br_target);
                end
            end else begin
                m_pend.delete();
            end
            if (!stall || flush) m_valid = 1'b1;
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_pc = RST_PC - 32'd4;
        m_valid = 1'b0;
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        flush = 1'b0; flush_target = '0;
        @(posedge clk);
        #1;

        // reset for two cycles, then free run
        apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("rst_addr", im_addr, RST_PC);
        tick();
        apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("rst_valid", 32'(de_valid), 32'd0);
        tick();
        idle();
        chk("c1_valid", 32'(de_valid), 32'd0);
        chk("c1_addr", im_addr, 32'hBFC0_0000);
        tick();
        idle();
        chk("c2_pc", de_pc, 32'hBFC0_0000);
        chk("c2_inst", de_inst, mem_word(32'hBFC0_0000));
        tick();
        idle();
        chk("c3_pc", de_pc, 32'hBFC0_0004);
        tick();

        // stall for three cycles on 0xBFC00008
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
            chk("stall_pc", de_pc, 32'hBFC0_0008);
            chk("stall_addr", im_addr, 32'hBFC0_0008);
            chk("stall_inst", de_inst, mem_word(32'hBFC0_0008));
            tick();
        end
        idle();
        chk("rel_addr", im_addr, 32'hBFC0_000C);
        tick();
        idle();
        chk("rel_pc", de_pc, 32'hBFC0_000C);
        tick();

        // taken branch: current word 0x10 is the delay slot and stays valid
        apply(1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'd0);
        chk("ds_pc", de_pc, 32'hBFC0_0010);
        chk("ds_valid", 32'(de_valid), 32'd1);
        tick();
        idle();
        chk("br_pc", de_pc, 32'hBFC0_0100);
        tick();

        // branch pulsed during a two-cycle stall
        apply(1'b0, 1'b1, 1'b1, 32'hBFC0_0200, 1'b0, 32'd0);
        tick();
        apply(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        idle();
        chk("bs_slot", de_pc, 32'hBFC0_0104);
        chk("bs_addr", im_addr, 32'hBFC0_0200);
        tick();
        idle();
        chk("bs_pc", de_pc, 32'hBFC0_0200);
        chk("bs_clr", im_addr, 32'hBFC0_0204);
        tick();

        // flush beats a simultaneous branch
        apply(1'b0, 1'b0, 1'b1, 32'hBFC0_0500, 1'b1, 32'hBFC0_0380);
        chk("fl_valid", 32'(de_valid), 32'd0);
        tick();
        // next word valid; redirect to a misaligned target
        apply(1'b0, 1'b0, 1'b1, 32'hBFC0_0102, 1'b0, 32'd0);
        chk("fl_pc", de_pc, 32'hBFC0_0380);
        chk("fl_valid2", 32'(de_valid), 32'd1);
        tick();
        idle();
        chk("mis_adel", 32'(de_adel), 32'd1);
        chk("mis_inst", de_inst, 32'd0);
        tick();

        // wrap around the top of the address space
        apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        tick();
        idle();
        chk("wrap_hi", de_pc, 32'hFFFF_FFFC);
        tick();
        idle();
        chk("wrap_lo", de_pc, 32'h0000_0000);
        tick();

        // reset while a redirect is pending discards it
        apply(1'b0, 1'b1, 1'b1, 32'hBFC0_0700, 1'b0, 32'd0);
        tick();
        apply(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        idle();
        chk("rp_addr", im_addr, RST_PC);
        tick();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, s, b, f;
            logic [31:0] bt, ft;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 30);
            b  = ($urandom_range(0, 99) < 20);
            f  = ($urandom_range(0, 99) < 6);
            bt = $urandom;
            ft = $urandom;
            if ($urandom_range(0, 9) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 9) != 0) ft[1:0] = 2'b00;
            apply(r, s, b, bt, f, ft);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
